dds_multi_nco: RTL and testbench

- Time-multiplexed, multi-channel numerically controlled oscillator (NCO).
- Each channel has its own phase accumulator, frequency tuning word (FTW) and phase offset.
- One shared quarter-wave sine LUT is used round-robin, producing interleaved sin/cos samples on a single AXI-stream output with channel tag and backpressure.
- Sits between the control register block and multi-carrier mixers; replaces per-carrier single-phase DDS instances.

---
 rtl/dds_pkg.sv | 35 +++
 rtl/dds_quarter_lut.sv | 111 +++++++++++
 rtl/dds_multi_nco.sv | 110 +++++++++++
 tb/tb_dds_multi_nco.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types, sizing helpers and sine-table generation for the DDS/NCO blocks.
package dds_pkg;

  typedef enum logic {
    CFG_FTW    = 1'b0,
    CFG_OFFSET = 1'b1
  } cfg_sel_t;

  typedef logic [1:0] quadrant_t;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 2) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int full_scale(input int out_dw);
    return (1 << (out_dw - 1)) - 1;
  endfunction

  // round(full_scale * sin(i*pi/2^(lut_dw+1))); the Taylor series is exact
  // to double precision over the first quadrant.
  function automatic int sine_entry(input int i, input int lut_dw, input int out_dw);
    real x;
    real term;
    real sum;
    x    = 3.14159265358979323846 * real'(i) / real'(1 << (lut_dw + 1));
    term = x;
    sum  = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return $rtoi(sum * real'(full_scale(out_dw)) + 0.5);
  endfunction

endpackage

// File: rtl/dds_quarter_lut.sv
// Phase-to-{sin,cos} converter built on a shared quarter-wave table.
// Three clock-enabled stages: index mirroring, table read, sign/full-scale fix-up.
module dds_quarter_lut
  import dds_pkg::*;
#(
  parameter int PHASE_DW = 32,
  parameter int LUT_DW   = 10,
  parameter int OUT_DW   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic [PHASE_DW-1:0]      phase_in,
  output logic signed [OUT_DW-1:0] sin_out,
  output logic signed [OUT_DW-1:0] cos_out
);

  localparam int LUT_N = 1 << LUT_DW;
  localparam logic signed [OUT_DW-1:0] FULL = OUT_DW'(full_scale(OUT_DW));

  logic signed [OUT_DW-1:0] lut_rom [LUT_N];

  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_rom
    assign lut_rom[gi] = OUT_DW'(sine_entry(gi, LUT_DW, OUT_DW));
  end

  quadrant_t           quad_in;
  logic [LUT_DW-1:0]   idx_in;
  logic [LUT_DW-1:0]   idx_neg;
  logic                unused_phase;

  quadrant_t                s1_quad_q, s1_quad_d, s2_quad_q, s2_quad_d;
  logic [LUT_DW-1:0]        s1_sin_idx_q, s1_sin_idx_d, s1_cos_idx_q, s1_cos_idx_d;
  logic                     s1_sin_full_q, s1_sin_full_d, s1_cos_full_q, s1_cos_full_d;
  logic                     s2_sin_full_q, s2_sin_full_d, s2_cos_full_q, s2_cos_full_d;
  logic signed [OUT_DW-1:0] s2_sin_lut_q, s2_sin_lut_d, s2_cos_lut_q, s2_cos_lut_d;
  logic signed [OUT_DW-1:0] sin_q, sin_d, cos_q, cos_d;
  logic signed [OUT_DW-1:0] sin_mag, cos_mag;

  assign quad_in      = phase_in[PHASE_DW-1 -: 2];
  assign idx_in       = phase_in[PHASE_DW-3 -: LUT_DW];
  assign idx_neg      = ~idx_in + LUT_DW'(1);
  assign unused_phase = ^phase_in;

  always_comb begin
    s1_quad_d     = s1_quad_q;
    s1_sin_idx_d  = s1_sin_idx_q;
    s1_cos_idx_d  = s1_cos_idx_q;
    s1_sin_full_d = s1_sin_full_q;
    s1_cos_full_d = s1_cos_full_q;
    s2_quad_d     = s2_quad_q;
    s2_sin_full_d = s2_sin_full_q;
    s2_cos_full_d = s2_cos_full_q;
    s2_sin_lut_d  = s2_sin_lut_q;
    s2_cos_lut_d  = s2_cos_lut_q;
    sin_d         = sin_q;
    cos_d         = cos_q;
    // A mirrored index of zero means the angle sits exactly on pi/2, which
    // the quarter table cannot hold.
    sin_mag       = s2_sin_full_q ? FULL : s2_sin_lut_q;
    cos_mag       = s2_cos_full_q ? FULL : s2_cos_lut_q;
    if (ce) begin
      s1_quad_d     = quad_in;
      s1_sin_idx_d  = quad_in[0] ? idx_neg : idx_in;
      s1_cos_idx_d  = quad_in[0] ? idx_in : idx_neg;
      s1_sin_full_d = quad_in[0] && (idx_in == '0);
      s1_cos_full_d = !quad_in[0] && (idx_in == '0);
      s2_quad_d     = s1_quad_q;
      s2_sin_full_d = s1_sin_full_q;
      s2_cos_full_d = s1_cos_full_q;
      s2_sin_lut_d  = lut_rom[s1_sin_idx_q];
      s2_cos_lut_d  = lut_rom[s1_cos_idx_q];
      sin_d         = s2_quad_q[1] ? -sin_mag : sin_mag;
      cos_d         = ((s2_quad_q == 2'd1) || (s2_quad_q == 2'd2)) ? -cos_mag : cos_mag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_quad_q     <= '0;
      s1_sin_idx_q  <= '0;
      s1_cos_idx_q  <= '0;
      s1_sin_full_q <= 1'b0;
      s1_cos_full_q <= 1'b0;
      s2_quad_q     <= '0;
      s2_sin_full_q <= 1'b0;
      s2_cos_full_q <= 1'b0;
      s2_sin_lut_q  <= '0;
      s2_cos_lut_q  <= '0;
      sin_q         <= '0;
      cos_q         <= '0;
    end else begin
      s1_quad_q     <= s1_quad_d;
      s1_sin_idx_q  <= s1_sin_idx_d;
      s1_cos_idx_q  <= s1_cos_idx_d;
      s1_sin_full_q <= s1_sin_full_d;
      s1_cos_full_q <= s1_cos_full_d;
      s2_quad_q     <= s2_quad_d;
      s2_sin_full_q <= s2_sin_full_d;
      s2_cos_full_q <= s2_cos_full_d;
      s2_sin_lut_q  <= s2_sin_lut_d;
      s2_cos_lut_q  <= s2_cos_lut_d;
      sin_q         <= sin_d;
      cos_q         <= cos_d;
    end
  end

  assign sin_out = sin_q;
  assign cos_out = cos_q;

endmodule

// File: rtl/dds_multi_nco.sv
// Time-multiplexed multi-channel NCO: round-robin phase issue into one shared
// quarter-wave converter, streamed out as {sin,cos} with channel tag and backpressure.
module dds_multi_nco
  import dds_pkg::*;
#(
  parameter int  NUM_CH   = 4,
  parameter int  PHASE_DW = 32,
  parameter int  LUT_DW   = 10,
  parameter int  OUT_DW   = 16,
  localparam int CH_W     = ch_w(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  phase_clear,
  input  logic                  cfg_wr_en,
  input  logic                  cfg_wr_sel,
  input  logic [CH_W-1:0]       cfg_wr_ch,
  input  logic [PHASE_DW-1:0]   cfg_wr_data,
  output logic [2*OUT_DW-1:0]   m_axis_out_tdata,
  output logic [CH_W-1:0]       m_axis_out_tuser,
  output logic                  m_axis_out_tlast,
  output logic                  m_axis_out_tvalid,
  input  logic                  m_axis_out_tready
);

  logic [NUM_CH-1:0][PHASE_DW-1:0] acc_q, acc_d, ftw_q, ftw_d, off_q, off_d;
  logic [CH_W-1:0]                 ch_idx_q, ch_idx_d;
  logic [PHASE_DW-1:0]             phase_q, phase_d;
  logic [3:0]                      vld_q, vld_d;
  logic [3:0][CH_W-1:0]            tag_q, tag_d;
  logic                            stall, ce, issue;
  cfg_sel_t                        wr_sel;
  logic signed [OUT_DW-1:0]        sin_s, cos_s;

  assign stall  = vld_q[3] && !m_axis_out_tready;
  assign ce     = !stall;
  assign issue  = enable && ce;
  assign wr_sel = cfg_sel_t'(cfg_wr_sel);

  always_comb begin
    acc_d    = acc_q;
    ftw_d    = ftw_q;
    off_d    = off_q;
    ch_idx_d = ch_idx_q;
    phase_d  = phase_q;
    vld_d    = vld_q;
    tag_d    = tag_q;
    // Valid and tag ride alongside the converter's three stages.
    if (ce) begin
      vld_d   = {vld_q[2:0], issue};
      tag_d   = {tag_q[2:0], ch_idx_q};
      phase_d = acc_q[ch_idx_q] + off_q[ch_idx_q];
    end
    if (issue) begin
      acc_d[ch_idx_q] = acc_q[ch_idx_q] + ftw_q[ch_idx_q];
      ch_idx_d        = (ch_idx_q == CH_W'(NUM_CH - 1)) ? '0 : ch_idx_q + CH_W'(1);
    end
    if (phase_clear) begin
      acc_d = '0;
    end
    // The issue above reads the _q copies, so a same-cycle write lands one issue later.
    if (cfg_wr_en && (int'(cfg_wr_ch) < NUM_CH)) begin
      if (wr_sel == CFG_FTW) begin
        ftw_d[cfg_wr_ch] = cfg_wr_data;
      end else begin
        off_d[cfg_wr_ch] = cfg_wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      ftw_q    <= '0;
      off_q    <= '0;
      ch_idx_q <= '0;
      phase_q  <= '0;
      vld_q    <= '0;
      tag_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      ftw_q    <= ftw_d;
      off_q    <= off_d;
      ch_idx_q <= ch_idx_d;
      phase_q  <= phase_d;
      vld_q    <= vld_d;
      tag_q    <= tag_d;
    end
  end

  dds_quarter_lut #(
    .PHASE_DW (PHASE_DW),
    .LUT_DW   (LUT_DW),
    .OUT_DW   (OUT_DW)
  ) u_lut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .phase_in (phase_q),
    .sin_out  (sin_s),
    .cos_out  (cos_s)
  );

  assign m_axis_out_tdata  = {sin_s, cos_s};
  assign m_axis_out_tuser  = tag_q[3];
  assign m_axis_out_tlast  = (tag_q[3] == CH_W'(NUM_CH - 1));
  assign m_axis_out_tvalid = vld_q[3];

endmodule

// File: tb/tb_dds_multi_nco.sv
// Directed self-checking bench for dds_multi_nco (4-channel main instance, 6-channel side instance).
module tb_dds_multi_nco;

  localparam logic [31:0] D_ZERO = 32'h0000_7FFF;  // phase 0:     {0, 32767}
  localparam logic [31:0] D_Q1   = 32'h7FFF_0000;  // phase pi/2:  {32767, 0}
  localparam logic [31:0] D_Q2   = 32'h0000_8001;  // phase pi:    {0, -32767}
  localparam logic [31:0] D_Q3   = 32'h8001_0000;  // phase 3pi/2: {-32767, 0}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        phase_clear = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic        cfg_wr_sel = 1'b0;
  logic [1:0]  cfg_wr_ch = '0;
  logic [31:0] cfg_wr_data = '0;
  logic        tready = 1'b1;
  logic [31:0] tdata;
  logic [1:0]  tuser;
  logic        tlast, tvalid;

  logic        enable2 = 1'b0;
  logic        pc2 = 1'b0;
  logic        cfg2_en = 1'b0;
  logic [2:0]  cfg2_ch = '0;
  logic [31:0] cfg2_data = '0;
  logic        tready2 = 1'b1;
  logic [31:0] tdata2;
  logic [2:0]  tuser2;
  logic        tlast2, tvalid2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dds_multi_nco #(.NUM_CH(4), .PHASE_DW(32), .LUT_DW(10), .OUT_DW(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .phase_clear(phase_clear),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel), .cfg_wr_ch(cfg_wr_ch),
    .cfg_wr_data(cfg_wr_data), .m_axis_out_tdata(tdata), .m_axis_out_tuser(tuser),
    .m_axis_out_tlast(tlast), .m_axis_out_tvalid(tvalid), .m_axis_out_tready(tready)
  );

  dds_multi_nco #(.NUM_CH(6), .PHASE_DW(32), .LUT_DW(10), .OUT_DW(16)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .phase_clear(pc2),
    .cfg_wr_en(cfg2_en), .cfg_wr_sel(cfg_wr_sel), .cfg_wr_ch(cfg2_ch),
    .cfg_wr_data(cfg2_data), .m_axis_out_tdata(tdata2), .m_axis_out_tuser(tuser2),
    .m_axis_out_tlast(tlast2), .m_axis_out_tvalid(tvalid2), .m_axis_out_tready(tready2)
  );

  typedef struct {
    logic        rdy;
    logic        vld;
    logic [1:0]  user;
    logic        last;
    logic [31:0] data;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; enable2 = 1'b0; phase_clear = 1'b0;
    cfg_wr_en = 1'b0; cfg2_en = 1'b0; tready = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic cfg(input logic sel, input logic [1:0] ch, input logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_wr_sel = sel; cfg_wr_ch = ch; cfg_wr_data = d;
    step();
    cfg_wr_en = 1'b0; cfg_wr_sel = 1'b0;
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Reference: sine/cosine of the phase truncated to its top 12 bits.
  function automatic logic [31:0] exp_data(input logic [31:0] phase);
    int  t, s, c;
    real a;
    t = int'(phase >> 20);
    a = 2.0 * 3.14159265358979323846 * real'(t) / 4096.0;
    s = rnd(32767.0 * $sin(a));
    c = rnd(32767.0 * $cos(a));
    return {s[15:0], c[15:0]};
  endfunction

  initial begin
    vec_t        tbl [20];
    logic [31:0] quarter [4];
    logic [31:0] ch2_q [$];
    logic [31:0] ch0_q [$];
    logic [31:0] pre_data, exp_ph;
    logic [1:0]  pre_user, exp_ch;
    logic        pre_acc, pre_stall;
    int          m, n2;
    logic [2:0]  exp_ch2;
    int          ch5_seen;

    // ---- reset state ----
    do_reset();
    reset = 1'b1;
    step();
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tdata", tdata, 32'h0);
    check("rst_tuser", tuser, 2'd0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_tvalid2", tvalid2, 1'b0);
    reset = 1'b0;

    // ---- quarter steps on ch0, static offset on ch1 ----
    quarter[0] = D_ZERO; quarter[1] = D_Q1; quarter[2] = D_Q2; quarter[3] = D_Q3;
    for (int r = 0; r < 20; r++) begin
      tbl[r].rdy  = 1'b1;
      tbl[r].vld  = (r >= 3);
      tbl[r].user = (r >= 3) ? 2'((r - 3) % 4) : 2'd0;
      tbl[r].last = (r >= 3) && (((r - 3) % 4) == 3);
      if (r < 3)                   tbl[r].data = 32'h0;
      else if (((r - 3) % 4) == 0) tbl[r].data = quarter[((r - 3) / 4) % 4];
      else if (((r - 3) % 4) == 1) tbl[r].data = D_Q1;
      else                         tbl[r].data = D_ZERO;
    end
    do_reset();
    cfg(1'b0, 2'd0, 32'h4000_0000);
    cfg(1'b1, 2'd1, 32'h4000_0000);
    enable = 1'b1;
    for (int r = 0; r < 20; r++) begin
      tready = tbl[r].rdy;
      step();
      check($sformatf("qs_vld[%0d]", r), tvalid, tbl[r].vld);
      if (tbl[r].vld) begin
        check($sformatf("qs_user[%0d]", r), tuser, tbl[r].user);
        check($sformatf("qs_last[%0d]", r), tlast, tbl[r].last);
        check($sformatf("qs_data[%0d]", r), tdata, tbl[r].data);
      end
    end

    // ---- random backpressure ----
    do_reset();
    cfg(1'b0, 2'd0, 32'h0100_0000);
    enable = 1'b1;
    m = 0;
    exp_ch = 2'd0;
    for (int i = 0; i < 1200; i++) begin
      tready    = ($urandom_range(0, 9) >= 3);
      pre_acc   = tvalid && tready;
      pre_stall = tvalid && !tready;
      pre_data  = tdata;
      pre_user  = tuser;
      step();
      if (pre_stall) check("bp_hold", {tvalid, tuser, tdata}, {1'b1, pre_user, pre_data});
      if (pre_acc) begin
        check("bp_order", pre_user, exp_ch);
        if (pre_user == 2'd0) begin
          exp_ph = 32'(m) << 24;
          check("bp_ch0", pre_data, exp_data(exp_ph));
          m++;
        end else begin
          check("bp_other", pre_data, D_ZERO);
        end
        exp_ch = exp_ch + 2'd1;
      end
    end
    check("bp_ch0_count", (m >= 100), 1'b1);
    enable = 1'b0;
    tready = 1'b1;

    // ---- phase_clear ----
    do_reset();
    cfg(1'b0, 2'd2, 32'h1000_0000);
    enable = 1'b1;
    for (int s = 1; s <= 70; s++) begin
      phase_clear = (s == 41);
      step();
      if (tvalid && (tuser == 2'd2)) ch2_q.push_back(tdata);
    end
    phase_clear = 1'b0;
    check("pc_count", (ch2_q.size() >= 14), 1'b1);
    for (int j = 0; j < 14 && j < ch2_q.size(); j++) begin
      exp_ph = (j < 10) ? (32'(j) << 28) : (32'(j - 10) << 28);
      check($sformatf("pc_ch2[%0d]", j), ch2_q[j], exp_data(exp_ph));
    end

    // ---- same-cycle FTW write on the issuing channel ----
    do_reset();
    cfg(1'b0, 2'd0, 32'h4000_0000);
    enable = 1'b1;
    for (int s = 1; s <= 24; s++) begin
      cfg_wr_en = (s == 5); cfg_wr_sel = 1'b0; cfg_wr_ch = 2'd0; cfg_wr_data = 32'h8000_0000;
      step();
      if (tvalid && (tuser == 2'd0)) ch0_q.push_back(tdata);
    end
    cfg_wr_en = 1'b0;
    check("sc_count", (ch0_q.size() >= 5), 1'b1);
    quarter[0] = D_ZERO; quarter[1] = D_Q1; quarter[2] = D_Q2; quarter[3] = D_ZERO;
    for (int j = 0; j < 5 && j < ch0_q.size(); j++)
      check($sformatf("sc_ch0[%0d]", j), ch0_q[j], (j == 4) ? D_Q2 : quarter[j]);

    // ---- out-of-range channel writes (6-channel instance) ----
    do_reset();
    cfg2_en = 1'b1; cfg2_data = 32'h4000_0000;
    cfg2_ch = 3'd6; step();
    cfg2_ch = 3'd7; step();
    cfg2_ch = 3'd5; step();
    cfg2_en = 1'b0;
    enable2 = 1'b1;
    n2 = 0; exp_ch2 = 3'd0; ch5_seen = 0;
    for (int s = 1; s <= 20; s++) begin
      step();
      if (tvalid2) begin
        n2++;
        check("oor_user", tuser2, exp_ch2);
        check("oor_last", tlast2, (exp_ch2 == 3'd5));
        if (tuser2 == 3'd5) begin
          check("oor_ch5", tdata2, (ch5_seen == 0) ? D_ZERO : D_Q1);
          ch5_seen++;
        end else begin
          check("oor_data", tdata2, D_ZERO);
        end
        exp_ch2 = (exp_ch2 == 3'd5) ? 3'd0 : exp_ch2 + 3'd1;
      end
    end
    check("oor_count", n2, 17);
    enable2 = 1'b0;

    // ---- reset mid-stream ----
    do_reset();
    cfg(1'b0, 2'd0, 32'h4000_0000);
    enable = 1'b1;
    for (int s = 0; s < 8; s++) step();
    check("mr_pre_vld", tvalid, 1'b1);
    reset = 1'b1; enable = 1'b0;
    step();
    check("mr_vld", tvalid, 1'b0);
    check("mr_data", tdata, 32'h0);
    check("mr_user", tuser, 2'd0);
    reset = 1'b0;
    cfg(1'b0, 2'd0, 32'h4000_0000);
    enable = 1'b1;
    step(); step(); step();
    check("mr_lat_vld", tvalid, 1'b0);
    step();
    check("mr_first_vld", tvalid, 1'b1);
    check("mr_first_user", tuser, 2'd0);
    check("mr_first_data", tdata, D_ZERO);
    step(); step(); step(); step();
    check("mr_second_user", tuser, 2'd0);
    check("mr_second_data", tdata, D_Q1);
    enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
